// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: passes core fetches through in RUN, and in a load
// packs a little-endian byte stream into 32-bit words written from BASE_ADDR upward.
module imem_load_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       NOP_INST  = 32'h0000_0013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_core_addr,
    output logic [31:0]       o_core_inst,
    output logic              o_core_hold,
    output logic              o_core_rst,
    input  logic              i_load_start,
    input  logic [ADDR_W-3:0] i_load_len,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-3:0] word_cnt;
    logic [ADDR_W-3:0] len_q;
    logic [31:0]       asm_q;
    logic [ADDR_W-1:0] word_addr;
    logic              byte_hs;
    logic              last_word;

    // Byte handshake: a byte transfers on a rising edge where i_byte_valid and
    // o_byte_ready are both high; the source holds data stable until then.
    assign byte_hs     = i_byte_valid & o_byte_ready;
    assign last_word   = (word_cnt == len_q - 1'b1);
    assign word_addr   = BASE_ADDR + {word_cnt, 2'b00};
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= RUN;
            byte_cnt <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            asm_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                RUN: begin
                    if (i_load_start) begin
                        len_q    <= i_load_len;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                COLLECT: begin
                    // byte_cnt wraps 3 -> 0 as the word completes
                    if (byte_hs) begin
                        asm_q[{byte_cnt, 3'b000} +: 8] <= i_byte_data;
                        byte_cnt                       <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    if (!last_word) word_cnt <= word_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        o_core_inst  = NOP_INST;
        o_core_hold  = 1'b1;
        o_core_rst   = 1'b0;
        o_byte_ready = 1'b0;
        o_busy       = 1'b1;
        o_mem_addr   = word_addr;
        o_mem_we     = 1'b0;
        o_mem_wdata  = asm_q;
        case (state)
            RUN: begin
                o_core_hold = 1'b0;
                o_busy      = 1'b0;
                o_mem_addr  = i_core_addr;
                o_core_inst = i_mem_rdata;
                if (i_load_start)
                    state_nx = (i_load_len == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                o_byte_ready = 1'b1;
                if (i_byte_valid && byte_cnt == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                o_mem_we = 1'b1;
                state_nx = last_word ? DONE : COLLECT;
            end
            DONE: begin
                o_core_rst = 1'b1;
                state_nx   = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: two instances (base 0 and a base that wraps),
// each backed by a 16-word memory model that logs every write.
module tb_imem_load_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] core_addr;
    logic        load_start, load_start2;
    logic [29:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        use2;

    logic [31:0] inst1, maddr1, wdata1, rdata1;
    logic        hold1, crst1, ready1, busy1, we1;
    logic [1:0]  st1;
    logic [31:0] inst2, maddr2, wdata2, rdata2;
    logic        hold2, crst2, ready2, busy2, we2;
    logic [1:0]  st2;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] wr2_addr_q [$];
    logic [31:0] wr2_data_q [$];
    logic [31:0] exp_q [$];
    int          wr_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic ready_sel;
    assign ready_sel = use2 ? ready2 : ready1;
    assign rdata1 = mem_a[maddr1[5:2]];
    assign rdata2 = mem_b[maddr2[5:2]];

    imem_load_ctrl #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000), .NOP_INST(NOP)) dut (
        .i_clk(clk), .i_rst(rst), .i_core_addr(core_addr), .o_core_inst(inst1),
        .o_core_hold(hold1), .o_core_rst(crst1), .i_load_start(load_start),
        .i_load_len(load_len), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .o_byte_ready(ready1), .o_busy(busy1), .o_mem_addr(maddr1), .o_mem_we(we1),
        .o_mem_wdata(wdata1), .i_mem_rdata(rdata1), .o_dbg_state(st1)
    );

    imem_load_ctrl #(.ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFC), .NOP_INST(NOP)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_core_addr(core_addr), .o_core_inst(inst2),
        .o_core_hold(hold2), .o_core_rst(crst2), .i_load_start(load_start2),
        .i_load_len(load_len), .i_byte_valid(byte_valid), .i_byte_data(byte_data),
        .o_byte_ready(ready2), .o_busy(busy2), .o_mem_addr(maddr2), .o_mem_we(we2),
        .o_mem_wdata(wdata2), .i_mem_rdata(rdata2), .o_dbg_state(st2)
    );

    always @(posedge clk) begin
        if (we1) begin
            mem_a[maddr1[5:2]] <= wdata1;
            wr_addr_q.push_back(maddr1);
            wr_data_q.push_back(wdata1);
            wr_cnt++;
        end
        if (we2) begin
            mem_b[maddr2[5:2]] <= wdata2;
            wr2_addr_q.push_back(maddr2);
            wr2_data_q.push_back(wdata2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            if (ready_sel) done = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL byte_handshake: byte %h never accepted within 20 cycles", b);
        end
    endtask

    task automatic start_load(input logic [29:0] len, input logic second);
        load_len = len;
        if (second) load_start2 = 1'b1; else load_start = 1'b1;
        tick();
        load_start  = 1'b0;
        load_start2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (hold1 !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", hold1); end
        n_cmp++; if (crst1 !== 1'b0) begin n_fail++; $display("FAIL reset_core_rst: got %b want 0", crst1); end
        n_cmp++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
        n_cmp++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we1); end
        n_cmp++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", st1); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_run_passthrough();
        core_addr = 32'h8;
        #1;
        n_cmp++; if (inst1 !== 32'hCAFE_0002) begin n_fail++; $display("FAIL run_inst: got %h want cafe0002", inst1); end
        n_cmp++; if (maddr1 !== 32'h8) begin n_fail++; $display("FAIL run_addr: got %h want 00000008", maddr1); end
        n_cmp++; if (hold1 !== 1'b0) begin n_fail++; $display("FAIL run_hold: got %b want 0", hold1); end
        core_addr = 32'hB;
        #1;
        n_cmp++; if (maddr1 !== 32'hB) begin n_fail++; $display("FAIL run_addr_low_bits: got %h want 0000000b", maddr1); end
        n_cmp++; if (inst1 !== 32'hCAFE_0002) begin n_fail++; $display("FAIL run_inst_unaligned: got %h want cafe0002", inst1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        start_load(30'd2, 1'b0);
        n_cmp++; if (st1 !== 2'd1) begin n_fail++; $display("FAIL b2b_collect: got state %0d want 1", st1); end
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        n_cmp++; if (we1 !== 1'b1) begin n_fail++; $display("FAIL b2b_we0: got %b want 1", we1); end
        n_cmp++; if (maddr1 !== 32'h0) begin n_fail++; $display("FAIL b2b_addr0: got %h want 00000000", maddr1); end
        n_cmp++; if (wdata1 !== 32'h0000_0013) begin n_fail++; $display("FAIL b2b_data0: got %h want 00000013", wdata1); end
        for (int i = 4; i < 8; i++) send_byte(bytes[i]);
        n_cmp++; if (we1 !== 1'b1) begin n_fail++; $display("FAIL b2b_we1: got %b want 1", we1); end
        n_cmp++; if (maddr1 !== 32'h4) begin n_fail++; $display("FAIL b2b_addr1: got %h want 00000004", maddr1); end
        n_cmp++; if (wdata1 !== 32'h0010_0093) begin n_fail++; $display("FAIL b2b_data1: got %h want 00100093", wdata1); end
        tick();
        n_cmp++; if (crst1 !== 1'b1) begin n_fail++; $display("FAIL b2b_core_rst: got %b want 1", crst1); end
        n_cmp++; if (hold1 !== 1'b1) begin n_fail++; $display("FAIL b2b_done_hold: got %b want 1", hold1); end
        n_cmp++; if (we1 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_we: got %b want 0", we1); end
        tick();
        n_cmp++; if (crst1 !== 1'b0) begin n_fail++; $display("FAIL b2b_core_rst_pulse: got %b want 0", crst1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_back_to_run: got %b want 0", busy1); end
        core_addr = 32'h4;
        #1;
        n_cmp++; if (inst1 !== 32'h0010_0093) begin n_fail++; $display("FAIL b2b_fetch_loaded: got %h want 00100093", inst1); end
    endtask

    task automatic test_gapped();
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
        exp_q.push_back(32'h0000_0013);
        exp_q.push_back(32'h0010_0093);
        core_addr = 32'h8;
        start_load(30'd2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i == 1) begin
                load_len   = 30'd5;
                load_start = 1'b1;
            end
            n_cmp++; if (inst1 !== NOP) begin n_fail++; $display("FAIL gap_nop[%0d]: got %h want %h", i, inst1, NOP); end
            n_cmp++; if (hold1 !== 1'b1) begin n_fail++; $display("FAIL gap_hold[%0d]: got %b want 1", i, hold1); end
            tick();
            load_start = 1'b0;
        end
        tick();
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL gap_back_to_run: got %b want 0", busy1); end
        n_cmp++; if (wr_data_q.size() !== 2) begin n_fail++; $display("FAIL gap_write_count: got %0d want 2", wr_data_q.size()); end
        for (int i = 0; i < 2 && wr_data_q.size() > 0; i++) begin
            logic [31:0] exp_d, got_d, got_a;
            exp_d = exp_q.pop_front();
            got_d = wr_data_q.pop_front();
            got_a = wr_addr_q.pop_front();
            n_cmp++; if (got_d !== exp_d) begin n_fail++; $display("FAIL gap_data[%0d]: got %h want %h", i, got_d, exp_d); end
            n_cmp++; if (got_a !== 32'(i * 4)) begin n_fail++; $display("FAIL gap_addr[%0d]: got %h want %h", i, got_a, i * 4); end
        end
    endtask

    task automatic test_zero_len();
        int wr0;
        wr0 = wr_cnt;
        start_load(30'd0, 1'b0);
        n_cmp++; if (st1 !== 2'd3) begin n_fail++; $display("FAIL zero_done_state: got %0d want 3", st1); end
        n_cmp++; if (crst1 !== 1'b1) begin n_fail++; $display("FAIL zero_core_rst: got %b want 1", crst1); end
        tick();
        n_cmp++; if (crst1 !== 1'b0) begin n_fail++; $display("FAIL zero_core_rst_pulse: got %b want 0", crst1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL zero_back_to_run: got %b want 0", busy1); end
        n_cmp++; if (wr_cnt !== wr0) begin n_fail++; $display("FAIL zero_no_write: got %0d writes want 0", wr_cnt - wr0); end
    endtask

    task automatic test_reset_mid_load();
        int wr0;
        wr0 = wr_cnt;
        start_load(30'd3, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (wr_cnt - wr0 !== 1) begin n_fail++; $display("FAIL abort_write_count: got %0d want 1", wr_cnt - wr0); end
        n_cmp++; if (st1 !== 2'd0) begin n_fail++; $display("FAIL abort_state: got %0d want 0", st1); end
        n_cmp++; if (hold1 !== 1'b0) begin n_fail++; $display("FAIL abort_hold: got %b want 0", hold1); end
        n_cmp++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", ready1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy1); end
        n_cmp++; if (crst1 !== 1'b0) begin n_fail++; $display("FAIL abort_core_rst: got %b want 0", crst1); end
        start_load(30'd1, 1'b0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        n_cmp++; if (wdata1 !== 32'h4433_2211) begin n_fail++; $display("FAIL reload_data: got %h want 44332211", wdata1); end
        n_cmp++; if (maddr1 !== 32'h0) begin n_fail++; $display("FAIL reload_addr: got %h want 00000000", maddr1); end
        tick(); tick();
    endtask

    task automatic test_addr_wrap();
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        use2 = 1'b1;
        start_load(30'd2, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        tick();
        n_cmp++; if (crst2 !== 1'b1) begin n_fail++; $display("FAIL wrap_core_rst: got %b want 1", crst2); end
        tick();
        n_cmp++; if (wr2_addr_q.size() !== 2) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 2", wr2_addr_q.size()); end
        if (wr2_addr_q.size() == 2) begin
            n_cmp++; if (wr2_addr_q[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", wr2_addr_q[0]); end
            n_cmp++; if (wr2_addr_q[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", wr2_addr_q[1]); end
            n_cmp++; if (wr2_data_q[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL wrap_data1: got %h want 00100093", wr2_data_q[1]); end
        end
        n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL wrap_other_idle: got %b want 0", busy1); end
        use2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; core_addr = '0; load_start = 1'b0; load_start2 = 1'b0;
        load_len = '0; byte_valid = 1'b0; byte_data = '0; use2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 32'hCAFE_0000 + 32'(i);
            mem_b[i] = 32'hBEEF_0000 + 32'(i);
        end
        test_reset();
        test_run_passthrough();
        test_back_to_back();
        test_gapped();
        test_zero_len();
        test_reset_mid_load();
        test_addr_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
